// File: rtl/hilo_divider_pkg.sv
// Shared types and constants for the HI/LO iterative divider.
// Optional feature macro: HILO_DIVIDER_SIGNED_EN (signed DIV support).
package hilo_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Cycles from the accepting edge to the edge showing done, counted inclusively
  localparam int DIV_LATENCY = DEFAULT_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/hilo_divider_if.sv
// CPU <-> divider handshake bundle; master is the execute stage, slave the divider.
// Used by hilo_divider (macro HILO_DIVIDER_SIGNED_EN only affects the divider).
interface hilo_divider_if
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/hilo_divider_div_step.sv
// One restoring division iteration: shift in the next dividend bit, compare, subtract.
// Purely combinational; unaffected by HILO_DIVIDER_SIGNED_EN.
module div_step
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    // quo_in doubles as the dividend shift register; its MSB is the next bit in
    rem_sh  = {rem_in, quo_in[WIDTH-1]};
    fits    = (rem_sh >= {2'b00, dvs});
    diff    = rem_sh[WIDTH:0] - {1'b0, dvs};
    rem_out = rem_sh[WIDTH:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_out = diff;
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle HI/LO divider for DIV/DIVU: WIDTH restoring steps, one sign-fix cycle.
// Define HILO_DIVIDER_SIGNED_EN to honour is_signed; otherwise every divide is unsigned.
module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  hilo_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

`ifdef HILO_DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  div_state_e              state;
  logic [CNT_W-1:0]        iter;
  logic [WIDTH:0]          rem_acc;
  logic [WIDTH-1:0]        quo_acc;
  logic [WIDTH-1:0]        dvs_mag;
  logic [WIDTH-1:0]        dvd_raw;
  logic                    neg_q;
  logic                    neg_r;
  logic                    dvs_zero;

  logic                    busy_r;
  logic                    done_r;
  logic                    dbz_r;
  logic [WIDTH-1:0]        quo_r;
  logic [WIDTH-1:0]        rem_r;

  logic [WIDTH:0]          rem_nxt;
  logic [WIDTH-1:0]        quo_nxt;
  logic                    op_signed;
  logic signed [WIDTH-1:0] dvd_s;
  logic signed [WIDTH-1:0] dvs_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    // The most-negative value maps onto itself, which is its correct unsigned magnitude
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign op_signed = SIGNED_EN & bus.is_signed;
  assign dvd_s     = bus.dividend;
  assign dvs_s     = bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_acc),
    .quo_in  (quo_acc),
    .dvs     (dvs_mag),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      iter   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state    <= ST_CALC;
            iter     <= '0;
            busy_r   <= 1'b1;
            dbz_r    <= 1'b0;
            rem_acc  <= '0;
            quo_acc  <= magnitude(dvd_s, op_signed);
            dvs_mag  <= magnitude(dvs_s, op_signed);
            dvd_raw  <= bus.dividend;
            neg_q    <= op_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r    <= op_signed & bus.dividend[WIDTH-1];
            dvs_zero <= (bus.divisor == '0);
          end else begin
            state <= ST_IDLE;
          end
        end

        // ---- iteration stage: one quotient bit per cycle ----
        ST_CALC: begin
          rem_acc <= rem_nxt;
          quo_acc <= quo_nxt;
          iter    <= iter + CNT_W'(1);
          if (iter == CNT_W'(WIDTH - 1)) begin
            state <= ST_FIX;
          end
        end

        // ---- sign-fix stage: results become architecturally visible ----
        ST_FIX: begin
          state  <= ST_DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          dbz_r  <= dvs_zero;
          if (dvs_zero) begin
            // Divide by zero reports the raw dividend, never a sign-fixed magnitude
            quo_r <= '1;
            rem_r <= dvd_raw;
          end else begin
            quo_r <= apply_sign(quo_acc, neg_q);
            rem_r <= apply_sign(rem_acc[WIDTH-1:0], neg_r);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: directed corner cases, random operands
// against a plain-arithmetic reference, start-ignore, back-to-back and reset cases.
module tb_hilo_divider;

`ifdef HILO_DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int LAT  = 34;
  localparam int BUSY = 33;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hilo_divider_if #(.WIDTH(32)) dif ();

  hilo_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  // Reference: MIPS DIV/DIVU semantics straight from integer arithmetic
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint sa, sb;
    dz = (b == 32'd0);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Call at a negedge; returns at the negedge where done is seen (or on budget expiry)
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input int inject, output int lat, output int bcnt,
                        output bit got, output logic dz_early);
    dif.start     = 1'b1;
    dif.is_signed = s;
    dif.dividend  = a;
    dif.divisor   = b;
    lat  = 0;
    bcnt = 0;
    got  = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    dif.start     = 1'b0;
    dif.dividend  = $urandom;
    dif.divisor   = $urandom;
    dif.is_signed = 1'($urandom_range(0, 1));
    dz_early      = dif.div_by_zero;
    for (int i = 0; i < 100; i++) begin
      if (dif.done) begin
        got = 1'b1;
        break;
      end
      if (dif.busy) bcnt++;
      dif.start = (inject != 0 && lat == inject);
      @(posedge clk);
      lat++;
      @(negedge clk);
      dif.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    dif.start = 1'b0; dif.is_signed = 1'b0; dif.dividend = '0; dif.divisor = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", dif.busy); end
    n_cmp++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", dif.done); end
    n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset dbz: got %b want 0", dif.div_by_zero); end
    n_cmp++; if (dif.quotient !== 32'd0) begin n_err++; $display("FAIL reset quotient: got %h want 0", dif.quotient); end
    n_cmp++; if (dif.remainder !== 32'd0) begin n_err++; $display("FAIL reset remainder: got %h want 0", dif.remainder); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t tbl [7];
    int lat, bcnt; bit got; logic dze;
    tbl[0] = '{32'd100, 32'd7, 1'b0, 32'h0000_000E, 32'h0000_0002, 1'b0};
    tbl[1] = '{32'hFFFF_FFF9, 32'h2, 1'b1,
               SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
               SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001, 1'b0};
    tbl[2] = '{32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    tbl[3] = '{32'h1234_5678, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               SIGNED_EN ? 32'h8000_0000 : 32'h0,
               SIGNED_EN ? 32'h0 : 32'h8000_0000, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[6] = '{32'h0000_0005, 32'h7, 1'b0, 32'h0, 32'h5, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, 0, lat, bcnt, got, dze);
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL dir%0d done_seen: got %b want 1", i, got); end
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL dir%0d latency: got %0d want %0d", i, lat, LAT); end
      n_cmp++; if (bcnt !== BUSY) begin n_err++; $display("FAIL dir%0d busy_cycles: got %0d want %0d", i, bcnt, BUSY); end
      n_cmp++; if (dze !== 1'b0) begin n_err++; $display("FAIL dir%0d dbz_after_start: got %b want 0", i, dze); end
      n_cmp++; if (dif.quotient !== tbl[i].q) begin n_err++; $display("FAIL dir%0d quotient: got %h want %h", i, dif.quotient, tbl[i].q); end
      n_cmp++; if (dif.remainder !== tbl[i].r) begin n_err++; $display("FAIL dir%0d remainder: got %h want %h", i, dif.remainder, tbl[i].r); end
      n_cmp++; if (dif.div_by_zero !== tbl[i].dz) begin n_err++; $display("FAIL dir%0d dbz: got %b want %b", i, dif.div_by_zero, tbl[i].dz); end
      @(negedge clk);
      n_cmp++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL dir%0d done_pulse_width: got %b want 0", i, dif.done); end
      n_cmp++; if (dif.quotient !== tbl[i].q) begin n_err++; $display("FAIL dir%0d quotient_hold: got %h want %h", i, dif.quotient, tbl[i].q); end
      n_cmp++; if (dif.div_by_zero !== tbl[i].dz) begin n_err++; $display("FAIL dir%0d dbz_hold: got %b want %b", i, dif.div_by_zero, tbl[i].dz); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq, er; logic edz, dze; bit s, got; int lat, bcnt;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      ref_div(a, b, s, eq, er, edz);
      run_op(a, b, s, 0, lat, bcnt, got, dze);
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rnd%0d latency: got %0d want %0d", i, lat, LAT); end
      n_cmp++; if (dif.quotient !== eq) begin n_err++; $display("FAIL rnd%0d quotient %h/%h s=%b: got %h want %h", i, a, b, s, dif.quotient, eq); end
      n_cmp++; if (dif.remainder !== er) begin n_err++; $display("FAIL rnd%0d remainder %h/%h s=%b: got %h want %h", i, a, b, s, dif.remainder, er); end
      n_cmp++; if (dif.div_by_zero !== edz) begin n_err++; $display("FAIL rnd%0d dbz: got %b want %b", i, dif.div_by_zero, edz); end
      // Half the time, issue the next start straight from DONE
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [31:0] eq, er; logic edz, dze; bit got; int lat, bcnt;
    ref_div(32'd1000, 32'd33, 1'b0, eq, er, edz);
    for (int k = 0; k < 2; k++) begin
      run_op(32'd1000, 32'd33, 1'b0, (k == 0) ? 5 : 33, lat, bcnt, got, dze);
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL ignore%0d latency: got %0d want %0d", k, lat, LAT); end
      n_cmp++; if (dif.quotient !== eq) begin n_err++; $display("FAIL ignore%0d quotient: got %h want %h", k, dif.quotient, eq); end
      n_cmp++; if (dif.remainder !== er) begin n_err++; $display("FAIL ignore%0d remainder: got %h want %h", k, dif.remainder, er); end
      @(negedge clk);
      n_cmp++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL ignore%0d busy_after: got %b want 0", k, dif.busy); end
    end
  endtask

  task automatic test_back_to_back();
    bit got; int lat, bcnt; logic dze;
    run_op(32'd100, 32'd7, 1'b0, 0, lat, bcnt, got, dze);
    n_cmp++; if (dif.quotient !== 32'h0E) begin n_err++; $display("FAIL b2b_first quotient: got %h want 0000000e", dif.quotient); end
    run_op(32'd12345, 32'd100, 1'b0, 0, lat, bcnt, got, dze);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_second latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (dif.quotient !== 32'd123) begin n_err++; $display("FAIL b2b_second quotient: got %h want %h", dif.quotient, 32'd123); end
    n_cmp++; if (dif.remainder !== 32'd45) begin n_err++; $display("FAIL b2b_second remainder: got %h want %h", dif.remainder, 32'd45); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got, seen; int lat, bcnt; logic dze;
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd999; dif.divisor = 32'd10;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    n_cmp++; if (dif.busy !== 1'b1) begin n_err++; $display("FAIL mid busy_before_reset: got %b want 1", dif.busy); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    n_cmp++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL mid busy: got %b want 0", dif.busy); end
    n_cmp++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL mid done: got %b want 0", dif.done); end
    n_cmp++; if (dif.quotient !== 32'd0) begin n_err++; $display("FAIL mid quotient: got %h want 0", dif.quotient); end
    n_cmp++; if (dif.remainder !== 32'd0) begin n_err++; $display("FAIL mid remainder: got %h want 0", dif.remainder); end
    n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL mid dbz: got %b want 0", dif.div_by_zero); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (dif.done || dif.busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid activity_after_reset: got %b want 0", seen); end
    // Reset held together with start must win
    reset = 1'b0; dif.start = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; dif.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL reset_vs_start busy: got %b want 0", dif.busy); end
    run_op(32'd999, 32'd10, 1'b0, 0, lat, bcnt, got, dze);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL mid_after latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (dif.quotient !== 32'd99) begin n_err++; $display("FAIL mid_after quotient: got %h want %h", dif.quotient, 32'd99); end
    n_cmp++; if (dif.remainder !== 32'd9) begin n_err++; $display("FAIL mid_after remainder: got %h want %h", dif.remainder, 32'd9); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hilo_divider.md
HILO_DIVIDER -- requirements
Module: hilo_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; the CPU instantiates it at 32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-004 Port: start  input  1  request pulse from the CPU execute stage for DIV/DIVU.
REQ-005 Port: is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 Port: dividend  input  WIDTH  rs value, sampled only on an accepted start.
REQ-007 Port: divisor  input  WIDTH  rt value, sampled only on an accepted start.
REQ-008 Port: busy  output  1  high while a division is in progress; the CPU stalls MFHI/MFLO on it.
REQ-009 Port: done  output  1  one-cycle pulse when the results are valid.
REQ-010 Port: quotient  output  WIDTH  LO value.
REQ-011 Port: remainder  output  WIDTH  HI value.
REQ-012 Port: div_by_zero  output  1  set with done when the divisor is 0; held until the next accepted start.

Function
REQ-013 States SHALL be IDLE, CALC, FIX and DONE.
REQ-014 start SHALL be accepted when the state is IDLE or DONE at a rising edge; acceptance latches the operands and is_signed and enters CALC with iteration count 0.
REQ-015 start SHALL be ignored in CALC or FIX, with no effect on the operation in progress.
REQ-016 CALC SHALL perform one restoring shift/subtract step per cycle for exactly WIDTH cycles on operand magnitudes, then go to FIX.
REQ-017 FIX SHALL last one cycle and apply signs. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend. This applies only when latched is_signed=1.
REQ-018 FIX SHALL then go to DONE; DONE lasts one cycle and goes to IDLE unless a new start is accepted.
REQ-019 Latency SHALL be WIDTH+2 cycles from the edge accepting start to the edge at which done=1 is visible (34 at WIDTH=32).
REQ-020 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-021 done SHALL be 1 only in DONE.
REQ-022 quotient and remainder SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-023 Divisor 0: quotient = all ones and remainder = dividend as latched (unsigned view), with div_by_zero=1; latency is unchanged.
REQ-024 Signed most-negative / -1 SHALL give quotient = most-negative and remainder = 0 (wraps, no trap).
REQ-025 Magnitude arithmetic SHALL use WIDTH+1 bits for the partial remainder so that no intermediate overflows.

Reset
REQ-026 With reset==0 at a rising edge, the state SHALL be IDLE and busy, done, div_by_zero, quotient and remainder SHALL be 0, in any state.
REQ-027 Reset mid-operation SHALL abandon the operation; no done pulse follows.
REQ-028 Reset SHALL take priority over a simultaneous start.

Configuration
REQ-029 Macro HILO_DIVIDER_SIGNED_EN: when defined, is_signed is honoured per REQ-017 and REQ-024.
REQ-030 When HILO_DIVIDER_SIGNED_EN is undefined, is_signed SHALL be ignored, all operations are unsigned, FIX still lasts one cycle, and latency is unchanged.

Structure
REQ-031 A shared package SHALL hold the state enum type and the constant DIV_LATENCY = WIDTH+2.
REQ-032 One sub-module, div_step, SHALL be the combinational single-iteration shift/compare/subtract; the FSM, counter and sign logic stay in hilo_divider.

Verification
REQ-033 Unsigned 100/7 -> quotient 0x0000000E, remainder 0x00000002, done exactly 34 cycles after start, busy high for 33 cycles.
REQ-034 Signed 0xFFFFFFF9 / 0x00000002 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; without HILO_DIVIDER_SIGNED_EN -> quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-035 0x12345678 / 0 (either mode) -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero=1; the next valid start clears div_by_zero.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-037 start re-pulsed with new operands during CALC -> ignored, original result delivered; start during DONE -> accepted, second done 34 cycles later.
REQ-038 reset=0 for one cycle at CALC iteration 10 -> all outputs 0 the next cycle, no done pulse; a following start completes normally.
